// File: rtl/pipelined_subtractor_core.sv
// Three-stage pipelined carry-select subtractor: diff = a - b - bin, computed as
// a + ~b + ~bin. Stage 1 forms both per-block sums plus block generate and
// propagate, stage 2 resolves block carries with a Kogge-Stone prefix, and
// stage 3 picks each block's sum and derives the flags. Valid-only protocol:
// fixed 3-cycle latency, no backpressure.

// Per-block work: both candidate sums (carry-in 0 and 1), block generate
// (carry out with carry-in 0) and block propagate (every bit of a ^ ~b set).
module pipelined_subtractor_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_blk,
  input  logic [BLOCK-1:0] b_blk,
  output logic [BLOCK-1:0] s0,
  output logic [BLOCK-1:0] s1,
  output logic             g,
  output logic             p
);
  logic [BLOCK:0] t0;

  assign t0 = {1'b0, a_blk} + {1'b0, ~b_blk};
  assign s0 = t0[BLOCK-1:0];
  assign s1 = t0[BLOCK-1:0] + BLOCK'(1);
  assign g  = t0[BLOCK];
  assign p  = &(a_blk ^ ~b_blk);
endmodule

// WIDTH must be a multiple of BLOCK and give at least two blocks.
module pipelined_subtractor_core #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             v_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             v_out
);
  localparam int NB     = WIDTH / BLOCK;
  localparam int LVL    = $clog2(NB);
  localparam int STAGES = 3;

  // valid shift register; vld_pipe[k] is the valid of stage k's registers
  logic [STAGES:1] vld_pipe;

  // stage 1 combinational block results
  logic [NB-1:0][BLOCK-1:0] s0_c, s1_c;
  logic [NB-1:0]            g_c, p_c;

  // stage 1 registers
  logic [NB-1:0][BLOCK-1:0] s0_1, s1_1;
  logic [NB-1:0]            g1, p1;
  logic                     cin1, am1, bm1;

  // stage 2 prefix result and registers
  logic [NB-1:0]            c_c;
  logic [NB-1:0][BLOCK-1:0] s0_2, s1_2;
  logic [NB-1:0]            sel2;
  logic                     cout2, am2, bm2;

  // stage 3 selected difference
  logic [WIDTH-1:0]         d3;

  pipelined_subtractor_block #(.BLOCK(BLOCK)) u_blk [NB-1:0] (
    .a_blk (a),
    .b_blk (b),
    .s0    (s0_c),
    .s1    (s1_c),
    .g     (g_c),
    .p     (p_c)
  );

  // valid tokens advance one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[STAGES-1:1], v_in};
  end

  assign v_out = vld_pipe[STAGES];

  // stage 1: capture block sums, G/P, carry-in and operand sign bits
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_1 <= '0;
      s1_1 <= '0;
      g1   <= '0;
      p1   <= '0;
      cin1 <= 1'b0;
      am1  <= 1'b0;
      bm1  <= 1'b0;
    end else if (v_in) begin
      s0_1 <= s0_c;
      s1_1 <= s1_c;
      g1   <= g_c;
      p1   <= p_c;
      cin1 <= ~bin;
      am1  <= a[WIDTH-1];
      bm1  <= b[WIDTH-1];
    end
  end

  // stage 2 prefix: group G/P over blocks 0..i, then fold in carry-in
  always_comb begin
    logic [NB-1:0] gk, pk, gn, pn;
    gk = g1;
    pk = p1;
    for (int l = 0; l < LVL; l++) begin
      gn = gk;
      pn = pk;
      for (int i = (1 << l); i < NB; i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i-(1<<l)]);
        pn[i] = pk[i] & pk[i-(1<<l)];
      end
      gk = gn;
      pk = pn;
    end
    c_c = gk | (pk & {NB{cin1}});
  end

  // stage 2: block i selects with the carry out of block i-1 (cin for block 0)
  always_ff @(posedge clk) begin
    if (rst) begin
      sel2  <= '0;
      cout2 <= 1'b0;
      s0_2  <= '0;
      s1_2  <= '0;
      am2   <= 1'b0;
      bm2   <= 1'b0;
    end else if (vld_pipe[1]) begin
      sel2  <= {c_c[NB-2:0], cin1};
      cout2 <= c_c[NB-1];
      s0_2  <= s0_1;
      s1_2  <= s1_1;
      am2   <= am1;
      bm2   <= bm1;
    end
  end

  // stage 3 mux: pick each block's precomputed sum
  always_comb begin
    d3 = '0;
    for (int i = 0; i < NB; i++)
      d3[i*BLOCK +: BLOCK] = sel2[i] ? s1_2[i] : s0_2[i];
  end

  // stage 3: register difference and flags together; hold between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
    end else if (vld_pipe[2]) begin
      diff <= d3;
      bout <= ~cout2;
      zero <= ~|d3;
      neg  <= d3[WIDTH-1];
      ovf  <= (am2 != bm2) && (d3[WIDTH-1] != am2);
    end
  end
endmodule

// File: tb/tb_pipelined_subtractor_core.sv
// Scoreboard bench for pipelined_subtractor_core. Two instances (32/8 and
// 16/4) share one stimulus stream; the 16-bit one sees the low operand halves.
// Expected results come from a plain-arithmetic model and are queued with the
// cycle on which they must appear.
module tb_pipelined_subtractor_core;
  typedef struct packed {
    logic [31:0] diff;
    logic        bout, zero, neg, ovf;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_in = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        bin = 1'b0;

  logic [31:0] diff32;
  logic        bout32, zero32, neg32, ovf32, vout32;
  logic [15:0] diff16;
  logic        bout16, zero16, neg16, ovf16, vout16;

  int   cyc = 0;
  logic rst_q = 1'b0;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$], q16[$];
  res_t last32 = '0, last16 = '0;

  pipelined_subtractor_core #(.WIDTH(32), .BLOCK(8)) dut32 (
    .clk(clk), .rst(rst), .v_in(v_in), .a(a), .b(b), .bin(bin),
    .diff(diff32), .bout(bout32), .zero(zero32), .neg(neg32), .ovf(ovf32),
    .v_out(vout32)
  );

  pipelined_subtractor_core #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .v_in(v_in), .a(a[15:0]), .b(b[15:0]), .bin(bin),
    .diff(diff16), .bout(bout16), .zero(zero16), .neg(neg16), .ovf(ovf16),
    .v_out(vout16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // reference: unsigned and signed integer arithmetic on w-bit operands
  function automatic res_t model(logic [31:0] x, logic [31:0] y, logic bi, int w);
    res_t r;
    longint unsigned mask, ux, uy;
    longint sx, sy, sr, lo, hi;
    mask = (64'd1 << w) - 64'd1;
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = longint'(ux);
    sy = longint'(uy);
    if (ux[w-1]) sx = sx - (longint'(1) << w);
    if (uy[w-1]) sy = sy - (longint'(1) << w);
    sr = sx - sy - longint'(bi);
    hi = (longint'(1) << (w-1)) - 1;
    lo = -(longint'(1) << (w-1));
    r.diff = 32'((ux - uy - {63'd0, bi}) & mask);
    r.bout = ux < (uy + {63'd0, bi});
    r.zero = (r.diff == 32'd0);
    r.neg  = r.diff[w-1];
    r.ovf  = (sr < lo) || (sr > hi);
    return r;
  endfunction

  task automatic cmp(string name, res_t act, res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got diff=%h bout=%b zero=%b neg=%b ovf=%b, want diff=%h bout=%b zero=%b neg=%b ovf=%b",
               name, cyc, act.diff, act.bout, act.zero, act.neg, act.ovf,
               exp.diff, exp.bout, exp.zero, exp.neg, exp.ovf);
    end
  endtask

  // one cycle of stimulus; a valid op queues its expected result
  task automatic drive(logic v, logic [31:0] x, logic [31:0] y, logic bi);
    v_in = v; a = x; b = y; bin = bi;
    if (v) begin
      q32.push_back('{model(x, y, bi, 32), cyc + 3});
      q16.push_back('{model(x, y, bi, 16), cyc + 3});
    end
    @(posedge clk); #1;
  endtask

  // directed op whose 32-bit result is given as a literal
  task automatic drive_k(logic [31:0] x, logic [31:0] y, logic bi, res_t k);
    v_in = 1'b1; a = x; b = y; bin = bi;
    q32.push_back('{k, cyc + 3});
    q16.push_back('{model(x, y, bi, 16), cyc + 3});
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'($urandom));
  endtask

  // monitor: pop on v_out, check timing and value; otherwise outputs must hold
  always @(negedge clk) begin
    if (rst_q) begin
      mon_en = 1'b1;
      last32 = '0;
      last16 = '0;
    end
    if (mon_en) begin
      if (vout32) begin
        if (q32.size() == 0) begin
          checks++; errors++;
          $display("FAIL v_out32 cyc=%0d: got v_out=1, want 0 (nothing pending)", cyc);
        end else begin
          exp_t e;
          e = q32.pop_front();
          checks++;
          if (e.due != cyc) begin
            errors++;
            $display("FAIL lat32: got v_out at cyc %0d, want cyc %0d", cyc, e.due);
          end
          cmp("res32", {diff32, bout32, zero32, neg32, ovf32}, e.r);
          last32 = e.r;
        end
      end else begin
        if (q32.size() != 0 && q32[0].due == cyc) begin
          checks++; errors++;
          $display("FAIL v_out32 cyc=%0d: got v_out=0, want 1", cyc);
          void'(q32.pop_front());
        end
        cmp("hold32", {diff32, bout32, zero32, neg32, ovf32}, last32);
      end

      if (vout16) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL v_out16 cyc=%0d: got v_out=1, want 0 (nothing pending)", cyc);
        end else begin
          exp_t e;
          e = q16.pop_front();
          checks++;
          if (e.due != cyc) begin
            errors++;
            $display("FAIL lat16: got v_out at cyc %0d, want cyc %0d", cyc, e.due);
          end
          cmp("res16", {16'd0, diff16, bout16, zero16, neg16, ovf16}, e.r);
          last16 = e.r;
        end
      end else begin
        if (q16.size() != 0 && q16[0].due == cyc) begin
          checks++; errors++;
          $display("FAIL v_out16 cyc=%0d: got v_out=0, want 1", cyc);
          void'(q16.pop_front());
        end
        cmp("hold16", {16'd0, diff16, bout16, zero16, neg16, ovf16}, last16);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset for 2 cycles, then idle: outputs must stay cleared
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(3);

    // directed cases
    drive_k(32'h0000_0005, 32'h0000_0003, 1'b0, '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(4);
    drive_k(32'h0000_0000, 32'h0000_0000, 1'b1, '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0});
    drive_k(32'h8000_0000, 32'h0000_0001, 1'b0, '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    drive_k(32'h1234_5678, 32'h1234_5678, 1'b0, '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0});
    drive_k(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1});
    idle(4);

    // back-to-back stream, a 2-cycle gap, then two more
    for (int i = 0; i < 8; i++)
      drive(1'b1, 32'(i) * 32'h0101_0101, 32'(i), 1'(i));
    idle(2);
    for (int i = 8; i < 10; i++)
      drive(1'b1, 32'(i) * 32'h0101_0101, 32'(i), 1'(i));
    idle(5);

    // reset mid-flight: op1 in flight, ops 2 and 3 land on reset cycles
    v_in = 1'b1; a = 32'd100; b = 32'd1; bin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; a = 32'd200; b = 32'd2;
    q32.delete(); q16.delete();
    @(posedge clk); #1;
    a = 32'd300; b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    drive(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    idle(5);

    // random regression at ~50% valid density
    for (int n = 0; n < 10000; ) begin
      if ($urandom_range(1, 0) == 1) begin
        drive(1'b1, $urandom, $urandom, 1'($urandom));
        n++;
      end else begin
        idle(1);
      end
    end

    // drain with a bounded wait
    for (int i = 0; i < 20 && (q32.size() != 0 || q16.size() != 0); i++) idle(1);
    idle(2);
    if (q32.size() != 0 || q16.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d/%0d results still pending, want 0/0", q32.size(), q16.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
